// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scan controller: register map, keymap,
// debounce states and per-frame scan result encoding.
// Pure declarations; no logic, no latency, no flow control.
package keypad_pkg;

  localparam logic [3:0] REG_DATA   = 4'h3;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h5;

  // Keycode lookup indexed [column][row]
  localparam logic [3:0] KEYMAP [0:3][0:3] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAND,
    ST_PRESSED
  } deb_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_KEY,
    FR_MULTI
  } frame_kind_e;

  typedef struct packed {
    frame_kind_e kind;
    logic [3:0]  code;
  } frame_res_t;

endpackage

// File: rtl/keypad_fifo.sv
// Small keycode queue (4-bit entries, DEPTH a power of two).
// head is combinational from storage; a push or pop lands at the next clk edge.
// Push while full is ignored unless a pop happens in the same cycle; pop while empty is ignored.
module keypad_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [3:0] push_dat,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [3:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en;
  logic          rd_en;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_ptr_q];
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  // Pointer, occupancy and storage updates
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (wr_en && !rd_en) begin
      cnt_d = cnt_q + 1'b1;
    end else if (rd_en && !wr_en) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column strobing, row sync, frame debounce, keycode FIFO, CPU register window.
// Latency: press stable before a frame -> not_empty after DEBOUNCE_SCANS frames + 1 cycle; reads are combinational.
// Keycodes pushed into a full FIFO are dropped and flag sticky overflow; optional irq under KEYPAD_IRQ_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  input  logic       we,
  input  logic       re,
  output logic [7:0] data_out,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       irq
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    row_s1_q, row_s2_q;
  logic          scan_q, scan_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    acc_n_q, acc_n_d;
  logic [3:0]    acc_code_q, acc_code_d;
  deb_state_e    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [1:0]    ctrl_q, ctrl_d;

  logic          frame_vld;
  frame_res_t    frame;
  logic          push;
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic [3:0]    fifo_head;
  logic [3:0]    col_keys;
  logic [2:0]    col_n, sum_n;
  logic [1:0]    key_row, merged_n;
  logic [3:0]    merged_code, cnt_inc;
  logic          unused_data_in;

  assign unused_data_in = &{1'b0, data_in[7:2]};
  assign col = scan_q ? ~(4'b1000 >> col_idx_q) : 4'hF;

  // Column dwell/step counters and per-frame key accumulation
  always_comb begin
    scan_d      = ctrl_d[0];
    dwell_d     = dwell_q;
    col_idx_d   = col_idx_q;
    acc_n_d     = acc_n_q;
    acc_code_d  = acc_code_q;
    frame_vld   = 1'b0;
    frame       = '{kind: FR_NONE, code: 4'h0};
    col_keys    = ~row_s2_q;
    col_n       = 3'($countones(col_keys));
    key_row     = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (col_keys[r]) key_row = 2'(r);
    end
    sum_n       = {1'b0, acc_n_q} + ((col_n > 3'd1) ? 3'd2 : col_n);
    merged_n    = (sum_n > 3'd1) ? 2'd2 : sum_n[1:0];
    merged_code = (acc_n_q == 2'd0 && col_n == 3'd1) ? KEYMAP[col_idx_q][key_row] : acc_code_q;
    if (!scan_q || !scan_d) begin
      dwell_d    = '0;
      col_idx_d  = 2'd0;
      acc_n_d    = 2'd0;
      acc_code_d = 4'h0;
    end else if (dwell_q == DWELL_LAST) begin
      dwell_d   = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (col_idx_q == 2'd3) begin
        frame_vld  = 1'b1;
        frame.code = merged_code;
        case (merged_n)
          2'd0:    frame.kind = FR_NONE;
          2'd1:    frame.kind = FR_KEY;
          default: frame.kind = FR_MULTI;
        endcase
        acc_n_d    = 2'd0;
        acc_code_d = 4'h0;
      end else begin
        acc_n_d    = merged_n;
        acc_code_d = merged_code;
      end
    end else begin
      dwell_d = dwell_q + 1'b1;
    end
  end

  // Debounce FSM: next state, candidate/frame counter and push strobe
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    cnt_inc = cnt_q + 4'd1;
    if (!scan_q || !scan_d) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end else if (frame_vld) begin
      case (state_q)
        ST_IDLE: begin
          if (frame.kind == FR_KEY) begin
            cand_d = frame.code;
            if (DEBOUNCE_SCANS == 1) begin
              push    = 1'b1;
              state_d = ST_PRESSED;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_CAND;
              cnt_d   = 4'd1;
            end
          end
        end
        ST_CAND: begin
          if (frame.kind == FR_KEY && frame.code == cand_q) begin
            if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
              push    = 1'b1;
              state_d = ST_PRESSED;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
          end
        end
        ST_PRESSED: begin
          if (frame.kind == FR_NONE) begin
            if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
              state_d = ST_IDLE;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // CPU writes: control register and overflow clear/set
  always_comb begin
    ctrl_d = ctrl_q;
    ovf_d  = ovf_q;
    pop    = re && (addr == REG_DATA) && !fifo_empty;
    if (we && addr == REG_CTRL) begin
`ifdef KEYPAD_IRQ_EN
      ctrl_d = data_in[1:0];
`else
      ctrl_d = {1'b0, data_in[0]};
`endif
    end
    if (we && addr == REG_STATUS && data_in[1]) begin
      ovf_d = 1'b0;
    end
    if (push && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // CPU read mux, zero when not selected
  always_comb begin
    data_out = 8'h00;
    if (re) begin
      case (addr)
        REG_DATA:   data_out = fifo_empty ? 8'h00 : {3'b000, 1'b1, fifo_head};
        REG_STATUS: data_out = {5'b0, (state_q == ST_PRESSED), ovf_q, !fifo_empty};
        REG_CTRL:   data_out = {6'b0, ctrl_q};
        default:    data_out = 8'h00;
      endcase
    end
  end

`ifdef KEYPAD_IRQ_EN
  assign irq = ctrl_q[1] & ~fifo_empty;
`else
  assign irq = 1'b0;
`endif

  keypad_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push    (push),
    .push_dat(cand_d),
    .pop     (pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // State registers; scan_q holds columns idle for the first cycle out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      scan_q     <= 1'b0;
      col_idx_q  <= 2'd0;
      dwell_q    <= '0;
      acc_n_q    <= 2'd0;
      acc_code_q <= 4'h0;
      state_q    <= ST_IDLE;
      cand_q     <= 4'h0;
      cnt_q      <= 4'd0;
      ovf_q      <= 1'b0;
      ctrl_q     <= 2'b01;
    end else begin
      row_s1_q   <= row;
      row_s2_q   <= row_s1_q;
      scan_q     <= scan_d;
      col_idx_q  <= col_idx_d;
      dwell_q    <= dwell_d;
      acc_n_q    <= acc_n_d;
      acc_code_q <= acc_code_d;
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      ctrl_q     <= ctrl_d;
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: keypad model driving rows from the columns,
// directed register/port checks queued with expected values and compared by a monitor.
// Build with or without KEYPAD_IRQ_EN to match the design.
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] addr;
  logic [7:0] data_in;
  logic       we;
  logic       re;
  logic [7:0] data_out;
  logic [3:0] row;
  logic [3:0] col;
  logic       irq;

  logic [15:0] pressed;   // index = col*4 + row
  logic        peek_vld;
  logic [1:0]  peek_sel;  // 0: col, 1: irq, 2: frame sync status
  logic        sync_ok;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } chk_t;
  chk_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SCAN_DIV      (8),
    .DEBOUNCE_SCANS(2),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .data_in (data_in),
    .we      (we),
    .re      (re),
    .data_out(data_out),
    .row     (row),
    .col     (col),
    .irq     (irq)
  );

  // Passive keypad: a pressed key shorts its row to the active-low column
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!col[3-c] && pressed[c*4+r]) row[r] = 1'b0;
      end
    end
  end

  // Monitor: compare whatever the DUT presents against the queued expectation
  always @(negedge clk) begin
    logic [7:0] got;
    chk_t       e;
    if (re || peek_vld) begin
      if (re) begin
        got = data_out;
      end else begin
        case (peek_sel)
          2'd0:    got = {4'h0, col};
          2'd1:    got = {7'h0, irq};
          default: got = {7'h0, sync_ok};
        endcase
      end
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: got 0x%02h, nothing expected", got);
      end else begin
        e = exp_q.pop_front();
        if (got === e.exp) n_pass++;
        else $display("FAIL %s: got 0x%02h, expected 0x%02h", e.name, got, e.exp);
      end
    end
  end

  function automatic logic [3:0] key_pos(input logic [3:0] code);
    case (code)
      4'h1: return {2'd0, 2'd0};
      4'h4: return {2'd0, 2'd1};
      4'h7: return {2'd0, 2'd2};
      4'h0: return {2'd0, 2'd3};
      4'h2: return {2'd1, 2'd0};
      4'h5: return {2'd1, 2'd1};
      4'h8: return {2'd1, 2'd2};
      4'hF: return {2'd1, 2'd3};
      4'h3: return {2'd2, 2'd0};
      4'h6: return {2'd2, 2'd1};
      4'h9: return {2'd2, 2'd2};
      4'hE: return {2'd2, 2'd3};
      4'hA: return {2'd3, 2'd0};
      4'hB: return {2'd3, 2'd1};
      4'hC: return {2'd3, 2'd2};
      default: return {2'd3, 2'd3};
    endcase
  endfunction

  task automatic press(input logic [3:0] code);
    pressed[key_pos(code)] = 1'b1;
  endtask

  task automatic release_all();
    pressed = 16'h0;
  endtask

  task automatic reg_read(input logic [3:0] a, input logic [7:0] exp, input string name);
    @(posedge clk); #1;
    addr = a;
    re   = 1'b1;
    exp_q.push_back('{name: name, exp: exp});
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    addr    = a;
    data_in = d;
    we      = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  // Observe a port in the current cycle, then advance one cycle
  task automatic peek(input logic [1:0] sel, input logic [7:0] exp, input string name);
    peek_sel = sel;
    peek_vld = 1'b1;
    exp_q.push_back('{name: name, exp: exp});
    @(posedge clk); #1;
    peek_vld = 1'b0;
  endtask

  // Return in the first cycle of a frame (column 0 just became active)
  task automatic sync_frame();
    logic [3:0] prev;
    bit         ok;
    ok   = 1'b0;
    prev = col;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (prev == 4'b1110 && col == 4'b0111) begin
        ok = 1'b1;
        break;
      end
      prev = col;
    end
    if (!ok) begin
      sync_ok = 1'b0;
      peek(2'd2, 8'h01, "sync_frame_timeout");
    end
  endtask

  initial begin
    logic [3:0] seq [5];
    seq = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4};
    reset_n  = 1'b0;
    addr     = 4'h0;
    data_in  = 8'h00;
    we       = 1'b0;
    re       = 1'b0;
    pressed  = 16'h0;
    peek_vld = 1'b0;
    peek_sel = 2'd0;
    sync_ok  = 1'b1;

    // 1. Reset state
    repeat (2) @(posedge clk);
    #1;
    peek(2'd0, 8'h0F, "col_in_reset");
    peek(2'd1, 8'h00, "irq_in_reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    peek(2'd0, 8'h07, "col_after_reset");
    reg_read(4'h3, 8'h00, "reset_data");
    reg_read(4'h4, 8'h00, "reset_status");
    reg_read(4'h5, 8'h01, "reset_ctrl");
    peek(2'd1, 8'h00, "reset_irq");

    // 2. Single press of key 5, read, release
    sync_frame();
    press(4'h5);
    repeat (96) @(posedge clk);
    reg_read(4'h4, 8'h05, "k5_status_held");
    reg_read(4'h3, 8'h15, "k5_data");
    reg_read(4'h3, 8'h00, "k5_data_empty");
    release_all();
    reg_read(4'h4, 8'h04, "k5_status_still_held");
    repeat (96) @(posedge clk);
    reg_read(4'h4, 8'h00, "k5_status_released");

    // 3. Bouncing key 9: alternating frames never debounce
    sync_frame();
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) press(4'h9);
      else release_all();
      repeat (32) @(posedge clk);
    end
    release_all();
    reg_read(4'h4, 8'h00, "bounce_status");

    // 4. Five presses without reads: FIFO fills, fifth key overflows
    for (int k = 0; k < 5; k++) begin
      sync_frame();
      press(seq[k]);
      repeat (96) @(posedge clk);
      release_all();
      repeat (96) @(posedge clk);
    end
    reg_read(4'h4, 8'h03, "ovf_status");
    reg_read(4'h3, 8'h11, "ovf_data0");
    reg_read(4'h3, 8'h12, "ovf_data1");
    reg_read(4'h3, 8'h13, "ovf_data2");
    reg_read(4'h3, 8'h1A, "ovf_data3");
    reg_read(4'h3, 8'h00, "ovf_data_empty");
    reg_read(4'h4, 8'h02, "ovf_status_drained");
    reg_write(4'h4, 8'h02);
    reg_read(4'h4, 8'h00, "ovf_status_cleared");

    // 5a. Two keys held together: MULTI frames, no push
    sync_frame();
    press(4'h1);
    press(4'h2);
    repeat (128) @(posedge clk);
    reg_read(4'h4, 8'h00, "multi_status");
    release_all();
    repeat (64) @(posedge clk);

    // 5b. Disable scanning in CAND, re-enable and restart from column 0
    sync_frame();
    press(4'h7);
    repeat (36) @(posedge clk);
    reg_write(4'h5, 8'h00);
    peek(2'd0, 8'h0F, "scan_off_col");
    repeat (100) @(posedge clk);
    reg_read(4'h4, 8'h00, "scan_off_status");
    reg_read(4'h5, 8'h00, "scan_off_ctrl");
    reg_write(4'h5, 8'h01);
    peek(2'd0, 8'h07, "scan_on_col");
    repeat (33) @(posedge clk);
    reg_read(4'h4, 8'h00, "restart_one_frame");
    repeat (30) @(posedge clk);
    reg_read(4'h4, 8'h05, "restart_pushed");
    reg_read(4'h3, 8'h17, "restart_data");
    release_all();
    repeat (96) @(posedge clk);

    // 6. Interrupt
`ifdef KEYPAD_IRQ_EN
    reg_write(4'h5, 8'h03);
    reg_read(4'h5, 8'h03, "irq_ctrl");
    sync_frame();
    press(4'hD);
    repeat (63) @(posedge clk);
    #1;
    peek(2'd1, 8'h00, "irq_push_cycle");
    peek(2'd1, 8'h01, "irq_after_push");
    reg_read(4'h3, 8'h1D, "irq_data");
    peek(2'd1, 8'h00, "irq_after_pop");
`else
    reg_write(4'h5, 8'h03);
    reg_read(4'h5, 8'h01, "noirq_ctrl");
    sync_frame();
    press(4'hD);
    repeat (64) @(posedge clk);
    #1;
    peek(2'd1, 8'h00, "noirq_irq");
    reg_read(4'h3, 8'h1D, "noirq_data");
`endif
    release_all();
    repeat (96) @(posedge clk);

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      $display("FAIL unconsumed_checks: got %0d pending, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks + exp_q.size());
    $finish;
  end

endmodule
